// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory port definitions.
// Used by the CPU datapath and the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int DMEM_DATA_W = 24;
    localparam int DMEM_ADDR_W = 8;

    typedef enum logic {
        PORT_CPU  = 1'b0,
        PORT_HOST = 1'b1
    } port_e;

endpackage

// File: rtl/dmem_prio.sv
// CPU-first priority select with a streak limit that
// forces a contending debug host through periodically.
module dmem_prio
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  cpu_req,
    input  logic  host_req,
    output port_e sel,
    output logic  gnt_valid
);

    localparam int CNT_W =
        (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_STREAK);

    logic [CNT_W-1:0] streak_cnt;
    logic [CNT_W-1:0] streak_nxt;
    logic             force_host;

    always_comb begin
        force_host = (streak_cnt == CNT_MAX);
        sel        = PORT_CPU;
        if (host_req && (!cpu_req || force_host)) begin
            sel = PORT_HOST;
        end
        gnt_valid  = rst_n & (cpu_req | host_req);
        // host_req with a CPU win is only reachable below the limit
        streak_nxt = streak_cnt;
        if (!host_req || sel == PORT_HOST) begin
            streak_nxt = '0;
        end else begin
            streak_nxt = streak_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_cnt <= '0;
        end else begin
            streak_cnt <= streak_nxt;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (CPU and debug host) in front
// of a single-port synchronous RAM, with read-return routing.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    port_e sel;
    port_e rd_owner;
    logic  gnt_valid;
    logic  rd_pend;

    dmem_prio #(
        .MAX_STREAK(MAX_STREAK)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .host_req (host_req),
        .sel      (sel),
        .gnt_valid(gnt_valid)
    );

    always_comb begin
        cpu_gnt   = gnt_valid && (sel == PORT_CPU);
        host_gnt  = gnt_valid && (sel == PORT_HOST);
        mem_en    = cpu_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    // Owner is captured at grant so the return cannot be stolen
    // by a grant to the other port in the rvalid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= PORT_CPU;
        end else begin
            rd_pend <= mem_en & ~mem_we;
            if (mem_en) begin
                rd_owner <= sel;
            end
        end
    end

    always_comb begin
        cpu_rvalid  = rd_pend && (rd_owner == PORT_CPU);
        host_rvalid = rd_pend && (rd_owner == PORT_HOST);
        cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
        host_rdata  = host_rvalid ? mem_rdata : '0;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 24, data word width (matches register width).
REQ-002 SHALL have parameter ADDR_W, default 8, data memory word-address width.
REQ-003 SHALL have parameter MAX_STREAK, default 4, consecutive contested CPU grants before the host is forced through.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req / cpu_we  in  1 / 1  CPU access request; 1 = store, 0 = load.
REQ-007 cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address and store data.
REQ-008 cpu_gnt / cpu_rvalid  out  1 / 1  CPU access issued this cycle; CPU load data valid this cycle.
REQ-009 cpu_rdata  out  DATA_W  CPU load data.
REQ-010 host_req / host_we / host_addr / host_wdata  in  1 / 1 / ADDR_W / DATA_W  debug-host port, same meaning as the CPU port.
REQ-011 host_gnt / host_rvalid / host_rdata  out  1 / 1 / DATA_W  host grant, read-valid and read data.
REQ-012 mem_en / mem_we / mem_addr / mem_wdata  out  1 / 1 / ADDR_W / DATA_W  single-port synchronous memory command.
REQ-013 mem_rdata  in  DATA_W  memory read data, valid the cycle after a read command.

Function
REQ-014 A requester SHALL hold req, we, addr and wdata stable from assertion until the cycle its gnt is high; gnt is a one-cycle pulse.
REQ-015 At most one gnt SHALL be high per cycle; mem_en SHALL equal cpu_gnt | host_gnt, and mem_we/addr/wdata SHALL come from the granted port, all combinational in the same cycle.
REQ-016 When exactly one port requests, that port SHALL be granted the same cycle (zero-cycle arbitration latency).
REQ-017 When both ports request, the CPU SHALL win unless streak_cnt == MAX_STREAK, in which case the host SHALL win.
REQ-018 streak_cnt SHALL increment on each contested cycle won by the CPU, saturate at MAX_STREAK, and clear on any host grant or any cycle without host_req.
REQ-019 A granted read SHALL raise that port's rvalid exactly one cycle after gnt, with rdata = mem_rdata; granted writes SHALL raise no rvalid.
REQ-020 A port SHALL be grantable on back-to-back cycles; a new grant in the rvalid cycle of a previous read is permitted (full throughput, one access per cycle).
REQ-021 The read-owner flag SHALL be registered at grant time so rvalid is routed to the original requester even if the other port is granted in the rvalid cycle.
REQ-022 cpu_rdata and host_rdata SHALL be 0 whenever the corresponding rvalid is low.
REQ-023 Write then read of the same address on consecutive grants SHALL return the written data (memory write-first behaviour is relied on; the arbiter adds no bypass).
REQ-024 Neither requesting: all gnt, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata SHALL be 0.

Reset
REQ-025 While rst_n = 0: streak_cnt = 0, read-owner/pending flags cleared, all gnt, rvalid and mem_en outputs 0, rdata outputs 0.
REQ-026 Reset asserted during an outstanding read SHALL discard it; no rvalid SHALL appear after rst_n is released.
REQ-027 The first grant SHALL be possible in the first rising edge cycle after rst_n deasserts.

Structure
REQ-028 DATA_W and ADDR_W defaults and the port-select encoding (PORT_CPU = 0, PORT_HOST = 1) SHALL live in a shared package used by the CPU and the arbiter.
REQ-029 The priority/streak logic SHALL be one sub-module, dmem_prio, (inputs cpu_req, host_req; output sel, gnt_valid; owns streak_cnt); the top module holds the read-return pipeline and the mux.

Verification
REQ-030 CPU store addr 0x05 data 0x00ABCD, next cycle CPU load 0x05 -> cpu_gnt both cycles, cpu_rvalid in cycle 3 with cpu_rdata = 0x00ABCD, host outputs 0.
REQ-031 Both ports request continuously, MAX_STREAK = 4 -> grant sequence CPU, CPU, CPU, CPU, HOST, CPU x4, HOST, repeating.
REQ-032 Host load 0x10 granted in cycle N, CPU load 0x11 granted in cycle N+1 -> host_rvalid at N+1 with mem[0x10], cpu_rvalid at N+2 with mem[0x11], no cross-routing.
REQ-033 Host-only requests, store 0x01..0x03 on three consecutive cycles -> host_gnt high three cycles, streak_cnt stays 0.
REQ-034 CPU load granted, rst_n pulled low on the following half-cycle -> cpu_rvalid never asserts; after release a CPU request is granted in its first cycle.
REQ-035 No requests for 10 cycles -> mem_en, mem_we, all gnt and rvalid 0 throughout.
